// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencer for the FRANK6000 core.
// Owns the program counter, the fetch handshake, the ALU start/done
// handshake and the 3-bit status register, and resolves conditional
// branches locally.
// Optional feature: define PC_SEQ_LINK_EN to add a link register with
// CALL (op 0x3) and RET (op 0x4); without it those opcodes run as NOP.
module pc_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_fetch_req,
    input  logic               i_fetch_ack,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_alu_en,
    input  logic               i_alu_done,
    input  logic [2:0]         i_alu_status,
    output logic [2:0]         o_status,
    output logic               o_jump_taken,
    output logic               o_halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h2;
`ifdef PC_SEQ_LINK_EN
    localparam logic [3:0] OP_CALL = 4'h3;
    localparam logic [3:0] OP_RET  = 4'h4;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [2:0]          status_q, status_d;
    logic                fetch_req_q, fetch_req_d;
    logic                alu_en_q, alu_en_d;
    logic                jump_taken_q, jump_taken_d;
    logic                halted_q, halted_d;
`ifdef PC_SEQ_LINK_EN
    logic [ADDR_W-1:0]   link_q, link_d;
`endif

    logic [3:0]          op;
    logic [1:0]          cc;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_inc;
    logic                cond_true;

    // Spare instruction bits between the cc field and the target are
    // carried in the IR but have no meaning to the sequencer.
    logic                unused_ir;
    assign unused_ir = ^ir_q;

    // Decode the latched instruction fields and evaluate the branch
    // condition against the registered status flags.
    always_comb begin
        op     = ir_q[INSTR_W-1 -: 4];
        cc     = ir_q[INSTR_W-5 -: 2];
        target = ir_q[ADDR_W-1:0];
        pc_inc = pc_q + ADDR_W'(1);
        cond_true = 1'b1;
        case (cc)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = status_q[0];
            2'b10:   cond_true = status_q[1];
            default: cond_true = status_q[2];
        endcase
    end

    // Next-state logic for the sequencer FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        status_d     = status_q;
        fetch_req_d  = 1'b0;
        alu_en_d     = 1'b0;
        jump_taken_d = 1'b0;
`ifdef PC_SEQ_LINK_EN
        link_d       = link_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Request rises one cycle after entry; an ack only
                // counts while the request is actually up.
                if (fetch_req_q && i_fetch_ack) begin
                    ir_d    = i_instr;
                    state_d = S_DECODE;
                end else begin
                    fetch_req_d = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_JMP: begin
                        if (cond_true) begin
                            pc_d         = target;
                            jump_taken_d = 1'b1;
                        end
                    end
                    OP_ALU: begin
                        state_d  = S_EXEC;
                        pc_d     = pc_q;
                        alu_en_d = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
`ifdef PC_SEQ_LINK_EN
                    OP_CALL: begin
                        if (cond_true) begin
                            link_d       = pc_inc;
                            pc_d         = target;
                            jump_taken_d = 1'b1;
                        end
                    end
                    OP_RET: begin
                        pc_d         = link_q;
                        jump_taken_d = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_EXEC: begin
                if (i_alu_done) begin
                    status_d = i_alu_status;
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        halted_d = (state_d == S_HALT);
    end

    // State and output registers; reset overrides any pending ack or done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            status_q     <= '0;
            fetch_req_q  <= 1'b0;
            alu_en_q     <= 1'b0;
            jump_taken_q <= 1'b0;
            halted_q     <= 1'b0;
`ifdef PC_SEQ_LINK_EN
            link_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            status_q     <= status_d;
            fetch_req_q  <= fetch_req_d;
            alu_en_q     <= alu_en_d;
            jump_taken_q <= jump_taken_d;
            halted_q     <= halted_d;
`ifdef PC_SEQ_LINK_EN
            link_q       <= link_d;
`endif
        end
    end

    assign o_pc         = pc_q;
    assign o_fetch_req  = fetch_req_q;
    assign o_alu_en     = alu_en_q;
    assign o_status     = status_q;
    assign o_jump_taken = jump_taken_q;
    assign o_halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer; expected values follow the
// PC_SEQ_LINK_EN setting of the build.
module tb_pc_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_run = 1'b0;
    logic [7:0]  o_pc;
    logic        o_fetch_req;
    logic        i_fetch_ack = 1'b0;
    logic [15:0] i_instr = '0;
    logic        o_alu_en;
    logic        i_alu_done = 1'b0;
    logic [2:0]  i_alu_status = '0;
    logic [2:0]  o_status;
    logic        o_jump_taken;
    logic        o_halted;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    localparam logic [15:0] I_NOP  = 16'h0000;
    localparam logic [15:0] I_ALU  = 16'h1000;
    localparam logic [15:0] I_HALT = 16'hF000;

    pc_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (i_run),
        .o_pc         (o_pc),
        .o_fetch_req  (o_fetch_req),
        .i_fetch_ack  (i_fetch_ack),
        .i_instr      (i_instr),
        .o_alu_en     (o_alu_en),
        .i_alu_done   (i_alu_done),
        .i_alu_status (i_alu_status),
        .o_status     (o_status),
        .o_jump_taken (o_jump_taken),
        .o_halted     (o_halted)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Apply reset for two edges, release it, and check every output is idle.
    task automatic test_reset(input string nm);
        @(negedge i_clk);
        i_rst = 1'b1; i_run = 1'b0; i_fetch_ack = 1'b0; i_alu_done = 1'b0;
        i_alu_status = '0; i_instr = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        tests++;
        if ({o_pc, o_status, o_fetch_req, o_alu_en, o_jump_taken, o_halted} !== 14'h0) begin
            fails++;
            $display("FAIL %s: pc=%h status=%b req=%b alu_en=%b jt=%b halted=%b, required all 0",
                     nm, o_pc, o_status, o_fetch_req, o_alu_en, o_jump_taken, o_halted);
        end
    endtask

    // Wait for a fetch request, check its address, ack it in the first
    // request cycle. Returns at the negedge of the DECODE cycle.
    task automatic do_fetch(input logic [15:0] instr, input logic [7:0] exp_pc,
                            input string nm, output int req_cyc);
        int n;
        n = 0;
        while (!o_fetch_req && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        req_cyc = cyc;
        tests++;
        if (!o_fetch_req) begin
            fails++;
            $display("FAIL %s_req: fetch request never rose, required 1", nm);
        end
        tests++;
        if (o_pc !== exp_pc) begin
            fails++;
            $display("FAIL %s_pc: o_pc=%h, required %h", nm, o_pc, exp_pc);
        end
        i_fetch_ack = 1'b1;
        i_instr     = instr;
        @(negedge i_clk);
        i_fetch_ack = 1'b0;
        i_instr     = '0;
    endtask

    // Wait for the ALU start pulse, answer dly cycles later, check status.
    task automatic do_alu(input int dly, input logic [2:0] st, input string nm);
        int n;
        n = 0;
        while (!o_alu_en && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        tests++;
        if (!o_alu_en) begin
            fails++;
            $display("FAIL %s_en: o_alu_en never rose, required 1", nm);
        end
        if (dly > 0) begin
            @(negedge i_clk);
            tests++;
            if (o_alu_en !== 1'b0) begin
                fails++;
                $display("FAIL %s_pulse: o_alu_en=%b one cycle later, required 0", nm, o_alu_en);
            end
            repeat (dly - 1) @(negedge i_clk);
        end
        i_alu_done   = 1'b1;
        i_alu_status = st;
        @(negedge i_clk);
        i_alu_done   = 1'b0;
        i_alu_status = '0;
        tests++;
        if (o_status !== st) begin
            fails++;
            $display("FAIL %s_status: o_status=%b, required %b", nm, o_status, st);
        end
    endtask

    // Check pc and jump pulse in the cycle after DECODE.
    task automatic check_after_decode(input logic [7:0] exp_pc, input logic exp_jt,
                                      input string nm);
        @(negedge i_clk);
        tests++;
        if (o_pc !== exp_pc || o_jump_taken !== exp_jt) begin
            fails++;
            $display("FAIL %s: pc=%h jt=%b, required pc=%h jt=%b",
                     nm, o_pc, o_jump_taken, exp_pc, exp_jt);
        end
    endtask

    task automatic test_nop_seq();
        int c0, c1, c2;
        test_reset("reset_nop");
        i_run = 1'b1;
        do_fetch(I_NOP, 8'h00, "nop0", c0);
        check_after_decode(8'h01, 1'b0, "nop0_dec");
        do_fetch(I_NOP, 8'h01, "nop1", c1);
        check_after_decode(8'h02, 1'b0, "nop1_dec");
        do_fetch(I_NOP, 8'h02, "nop2", c2);
        check_after_decode(8'h03, 1'b0, "nop2_dec");
        tests++;
        if (c1 - c0 != 3 || c2 - c1 != 3) begin
            fails++;
            $display("FAIL nop_latency: cycles %0d and %0d, required 3 and 3", c1 - c0, c2 - c1);
        end
    endtask

    // ALU at 0x05 with status 010, then JMP with the given condition.
    task automatic test_alu_jmp(input logic [15:0] jmp, input logic [7:0] exp_pc,
                                input logic exp_jt, input string nm);
        int c;
        test_reset({nm, "_reset"});
        i_run = 1'b1;
        do_fetch(16'h2005, 8'h00, {nm, "_j5"}, c);
        check_after_decode(8'h05, 1'b1, {nm, "_j5_dec"});
        do_fetch(I_ALU, 8'h05, {nm, "_alu"}, c);
        do_alu(2, 3'b010, {nm, "_alu"});
        do_fetch(jmp, 8'h06, {nm, "_jmp"}, c);
        check_after_decode(exp_pc, exp_jt, {nm, "_jmp_dec"});
        @(negedge i_clk);
        tests++;
        if (o_jump_taken !== 1'b0 || o_status !== 3'b010) begin
            fails++;
            $display("FAIL %s_after: jt=%b status=%b, required jt=0 status=010",
                     nm, o_jump_taken, o_status);
        end
    endtask

    task automatic test_wrap();
        int c;
        test_reset("reset_wrap");
        i_run = 1'b1;
        do_fetch(16'h20FF, 8'h00, "wrap_j", c);
        check_after_decode(8'hFF, 1'b1, "wrap_j_dec");
        do_fetch(I_NOP, 8'hFF, "wrap_nop", c);
        check_after_decode(8'h00, 1'b0, "wrap_nop_dec");
        do_fetch(16'h2000, 8'h00, "wrap_j0", c);
        check_after_decode(8'h00, 1'b1, "wrap_j0_dec");
    endtask

    task automatic test_halt();
        int c;
        test_reset("reset_halt");
        i_run = 1'b1;
        do_fetch(16'h2010, 8'h00, "halt_j", c);
        check_after_decode(8'h10, 1'b1, "halt_j_dec");
        do_fetch(I_HALT, 8'h10, "halt", c);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            tests++;
            if (o_halted !== 1'b1 || o_pc !== 8'h10 || o_fetch_req !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold%0d: halted=%b pc=%h req=%b, required 1 10 0",
                         i, o_halted, o_pc, o_fetch_req);
            end
        end
        test_reset("halt_exit");
    endtask

    task automatic test_reset_fetch();
        int n;
        test_reset("reset_rf");
        i_run = 1'b1;
        n = 0;
        while (!o_fetch_req && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        tests++;
        if (!o_fetch_req) begin
            fails++;
            $display("FAIL rf_req: fetch request never rose, required 1");
        end
        i_rst = 1'b1; i_fetch_ack = 1'b1; i_instr = I_HALT; i_run = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        tests++;
        if ({o_pc, o_status, o_fetch_req, o_alu_en, o_jump_taken, o_halted} !== 14'h0) begin
            fails++;
            $display("FAIL rf_outputs: pc=%h status=%b req=%b halted=%b, required all 0",
                     o_pc, o_status, o_fetch_req, o_halted);
        end
        repeat (3) begin
            @(negedge i_clk);
            tests++;
            if (o_fetch_req !== 1'b0 || o_halted !== 1'b0 || o_pc !== 8'h00) begin
                fails++;
                $display("FAIL rf_late_ack: req=%b halted=%b pc=%h, required 0 0 00",
                         o_fetch_req, o_halted, o_pc);
            end
        end
        i_fetch_ack = 1'b0;
        i_instr     = '0;
    endtask

    task automatic test_reset_exec();
        int c, n;
        test_reset("reset_re");
        i_run = 1'b1;
        do_fetch(I_ALU, 8'h00, "re_alu0", c);
        do_alu(0, 3'b111, "re_alu0");
        do_fetch(I_ALU, 8'h01, "re_alu1", c);
        n = 0;
        while (!o_alu_en && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        tests++;
        if (!o_alu_en) begin
            fails++;
            $display("FAIL re_en: o_alu_en never rose, required 1");
        end
        i_rst = 1'b1; i_alu_done = 1'b1; i_alu_status = 3'b101; i_run = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        tests++;
        if ({o_pc, o_status, o_fetch_req, o_alu_en, o_jump_taken, o_halted} !== 14'h0) begin
            fails++;
            $display("FAIL re_outputs: pc=%h status=%b alu_en=%b req=%b, required all 0",
                     o_pc, o_status, o_alu_en, o_fetch_req);
        end
        repeat (2) begin
            @(negedge i_clk);
            tests++;
            if (o_status !== 3'b000 || o_pc !== 8'h00) begin
                fails++;
                $display("FAIL re_late_done: status=%b pc=%h, required 000 00", o_status, o_pc);
            end
        end
        i_alu_done   = 1'b0;
        i_alu_status = '0;
    endtask

    task automatic test_call_ret();
        int c;
        test_reset("reset_cr");
        i_run = 1'b1;
        do_fetch(16'h2008, 8'h00, "cr_j8", c);
        check_after_decode(8'h08, 1'b1, "cr_j8_dec");
        do_fetch(16'h3020, 8'h08, "cr_call", c);
`ifdef PC_SEQ_LINK_EN
        check_after_decode(8'h20, 1'b1, "cr_call_dec");
        do_fetch(16'h4000, 8'h20, "cr_ret", c);
        check_after_decode(8'h09, 1'b1, "cr_ret_dec");
`else
        check_after_decode(8'h09, 1'b0, "cr_call_dec");
        do_fetch(16'h4000, 8'h09, "cr_ret", c);
        check_after_decode(8'h0A, 1'b0, "cr_ret_dec");
`endif
    endtask

    initial begin
        test_reset("reset_initial");
        test_nop_seq();
        test_alu_jmp(16'h2840, 8'h40, 1'b1, "jmp_cc10");
        test_alu_jmp(16'h2440, 8'h07, 1'b0, "jmp_cc01");
        test_wrap();
        test_halt();
        test_reset_fetch();
        test_reset_exec();
        test_call_ret();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction sequencer for the FRANK6000 core.
- Owns the program counter, the fetch handshake, the ALU start/done handshake and the 3-bit status register.
- Evaluates branch conditions with the jump-condition rule below, so control flow is fully sequenced in one block.
- Sits between instruction memory, the ALU datapath and the top-level run control.

Parameters:
- ADDR_W, 8, program counter / instruction address width.
- INSTR_W, 16, instruction width; must be >= ADDR_W+6.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_run  input  1  level; leaves IDLE when high.
- o_pc  output  ADDR_W  current program counter.
- o_fetch_req  output  1  instruction fetch request for address o_pc.
- i_fetch_ack  input  1  fetch complete; i_instr valid this cycle.
- i_instr  input  INSTR_W  fetched instruction.
- o_alu_en  output  1  one-cycle ALU start pulse.
- i_alu_done  input  1  ALU finished; i_alu_status valid this cycle.
- i_alu_status  input  3  ALU flags {f2,f1,f0}.
- o_status  output  3  registered status flags.
- o_jump_taken  output  1  one-cycle pulse when PC was loaded from a branch target.
- o_halted  output  1  high while in HALT.

Behaviour:
- Reset (synchronous, any state, including mid-handshake):
  - state=IDLE; o_pc=0, o_status=0, instruction register=0.
  - o_fetch_req, o_alu_en, o_jump_taken, o_halted all 0 from the cycle after the reset edge.
  - A pending ack or done is discarded.
- Instruction fields:
  - op = instr[INSTR_W-1:INSTR_W-4].
  - cc = instr[INSTR_W-5:INSTR_W-6].
  - target = instr[ADDR_W-1:0].
- Opcodes:
  - 0x0 NOP.
  - 0x1 ALU.
  - 0x2 JMP (conditional).
  - 0xF HALT.
  - All others are executed as NOP.
- Condition rule:
  - cc=00: always true.
  - cc=01: o_status[0].
  - cc=10: o_status[1].
  - cc=11: o_status[2].
  - Evaluated on the registered status at DECODE.
- States:
  - IDLE: outputs idle; i_run=1 -> FETCH.
  - FETCH:
    - o_fetch_req=1 (registered; first high the cycle after entry).
    - Holds until i_fetch_ack=1.
    - On the ack edge: latch i_instr, -> DECODE.
    - Ack in the first req cycle is legal.
    - Ack while req=0 is ignored.
  - DECODE (1 cycle):
    - NOP/other: pc <= pc+1, -> FETCH.
    - JMP true: pc <= target, o_jump_taken=1 next cycle, -> FETCH.
    - JMP false: pc <= pc+1, -> FETCH.
    - ALU: -> EXEC.
    - HALT: -> HALT; pc unchanged.
  - EXEC:
    - o_alu_en=1 for exactly the first cycle in EXEC.
    - Wait for i_alu_done, then o_status <= i_alu_status, pc <= pc+1, -> FETCH.
    - i_alu_done in the same cycle as o_alu_en is accepted.
  - HALT: o_halted=1; i_run ignored; exit only via i_rst.
- Latency:
  - Zero-wait-state fetch: NOP = 3 cycles (FETCH req, ack, DECODE).
  - ALU = 3 + ALU cycles.
- PC arithmetic: pc+1 wraps modulo 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8); no overflow flag.
- Simultaneous events:
  - i_rst wins over ack/done.
  - Dropping i_run outside IDLE has no effect; the sequence keeps running.
- o_status changes only on ALU completion or reset.

Optional Feature:
- Macro PC_SEQ_LINK_EN.
- Defined:
  - Adds an ADDR_W link register, reset 0.
  - op 0x3 CALL: condition evaluated as for JMP.
    - True: link <= pc+1 (wrapped), pc <= target, o_jump_taken pulse.
    - False: pc <= pc+1, link unchanged.
  - op 0x4 RET: pc <= link, o_jump_taken pulse.
- Undefined: 0x3/0x4 are NOP; no link register is synthesized.

Test Plan:
- Reset, i_run=1, ack on the first req cycle, instrs NOP at pc 0..2 -> o_pc 0,1,2; exactly 3 cycles per instr; o_jump_taken never high.
- ALU at pc 0x05, i_alu_done 2 cycles after o_alu_en with status 3'b010; next JMP cc=10 target 0x40 -> o_status=010, o_pc=0x40, one o_jump_taken pulse. Same JMP with cc=01 -> o_pc=0x07.
- NOP at pc 0xFF -> o_pc wraps to 0x00. JMP cc=00 target 0x00 with status 0 -> taken.
- HALT at pc 0x10 -> o_halted=1, o_pc stays 0x10, o_fetch_req=0 for 20 cycles despite i_run=1. Then i_rst -> o_halted=0, o_pc=0.
- i_rst asserted during FETCH while req=1 and during EXEC before done -> all outputs 0 the next cycle; a late ack/done is ignored; o_status=0.
- PC_SEQ_LINK_EN: CALL cc=00 target 0x20 at pc 0x08, then RET at 0x20 -> o_pc 0x20 then 0x09, two o_jump_taken pulses. Without the macro, same program -> o_pc 0x09 then 0x0A.
